// File: rtl/prog_sequencer.sv
// Fetch/decode sequencer: PC drives program memory, the returned word decodes to datapath strobes.
// Zero-cycle decode, one instruction retired per RUN cycle, no backpressure; stops on HLT or illegal opcode.
module prog_sequencer #(
  parameter int addr_bus  = 11,
  parameter int data_size = 16,
  parameter int cnt_size  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [data_size-1:0] Instr,
  output logic [addr_bus-1:0]  Prog_Addr,
  output logic [addr_bus-1:0]  Data_Addr,
  output logic                 Wr_Mem,
  output logic [1:0]           Sel_A,
  output logic                 Sel_B,
  output logic                 Wr_Acc,
  output logic                 Op,
  output logic                 Running,
  output logic                 Halted,
  output logic                 Illegal,
  output logic [cnt_size-1:0]  Instr_Count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;

  localparam logic [addr_bus-1:0] PC_ONE  = {{(addr_bus-1){1'b0}}, 1'b1};
  localparam logic [cnt_size-1:0] CNT_ONE = {{(cnt_size-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [addr_bus-1:0] pc_q, pc_d;
  logic                illegal_q, illegal_d;
  logic [cnt_size-1:0] cnt_q, cnt_d;

  logic [4:0] opcode;
  logic       run;
  logic       op_legal;

  assign opcode   = Instr[data_size-1 -: 5];
  assign run      = (state_q == S_RUN);
  assign op_legal = (opcode <= OP_SUBI);

  // Strobes are purely combinational from the fetched word, qualified by RUN.
  always_comb begin
    Wr_Mem = 1'b0;
    Wr_Acc = 1'b0;
    Sel_A  = 2'd0;
    Sel_B  = 1'b0;
    Op     = 1'b0;
    if (run) begin
      case (opcode)
        OP_STO:  Wr_Mem = 1'b1;
        OP_LD:   Wr_Acc = 1'b1;
        OP_LDI:  begin Wr_Acc = 1'b1; Sel_A = 2'd1; end
        OP_ADD:  begin Wr_Acc = 1'b1; Sel_A = 2'd2; end
        OP_ADDI: begin Wr_Acc = 1'b1; Sel_A = 2'd2; Sel_B = 1'b1; end
        OP_SUB:  begin Wr_Acc = 1'b1; Sel_A = 2'd2; Op = 1'b1; end
        OP_SUBI: begin Wr_Acc = 1'b1; Sel_A = 2'd2; Sel_B = 1'b1; Op = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_RUN: begin
        if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else if (!op_legal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          pc_d = pc_q + PC_ONE;
          if (!(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
        end
      end
      // IDLE, HALT and the unused encoding all restart on Start.
      default: begin
        if (Start) begin
          state_d   = S_RUN;
          pc_d      = '0;
          illegal_d = 1'b0;
          cnt_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Prog_Addr   = pc_q;
  assign Data_Addr   = Instr[addr_bus-1:0];
  assign Running     = run;
  assign Halted      = (state_q == S_HALT);
  assign Illegal     = illegal_q;
  assign Instr_Count = cnt_q;

endmodule
